// File: rtl/mem_port_arbiter.sv
// Arbitrates main-memory port 1 between I-cache refill and D-cache refill/write-back.
// One transaction in flight, round-robin on ties, timeout completion on a missing Ready.
module mem_port_arbiter #(
  parameter int unsigned BLOCKSIZE      = 128,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned BYTE_ADDR_BITS = 4,
  parameter int unsigned TIMEOUT        = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ireq_i,
  input  logic [ADDR_W-1:0]    iaddr_i,
  output logic                 iack_o,
  input  logic                 dreq_i,
  input  logic                 dwen_i,
  input  logic [ADDR_W-1:0]    daddr_i,
  input  logic [BLOCKSIZE-1:0] dwdata_i,
  output logic                 dack_o,
  output logic [BLOCKSIZE-1:0] rdata_o,
  output logic                 err_o,
  output logic                 mem_valid_o,
  output logic                 mem_wen_o,
  output logic [ADDR_W-1:0]    mem_raddr_o,
  output logic [ADDR_W-1:0]    mem_waddr_o,
  output logic [BLOCKSIZE-1:0] mem_wdata_o,
  input  logic                 mem_ready_i,
  input  logic [BLOCKSIZE-1:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic                 owner_q;      // 1: D-cache owns the transaction
  logic                 last_d_q;     // 1: last completed grant went to D-cache
  logic                 wen_q;
  logic                 timed_out_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BLOCKSIZE-1:0] wdata_q;
  logic [BLOCKSIZE-1:0] rdata_q;
  logic [CntW-1:0]      cnt_q;
  logic                 grant_d;
  logic                 any_req;
  logic                 cnt_expired;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr_i[BYTE_ADDR_BITS-1:0], daddr_i[BYTE_ADDR_BITS-1:0]};

  assign any_req     = ireq_i | dreq_i;
  assign cnt_expired = (cnt_q == CntW'(TIMEOUT - 1));
  // On a tie the requester that did not win last time is granted.
  assign grant_d     = (ireq_i && dreq_i) ? ~last_d_q : dreq_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mem_ready_i || cnt_expired) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q     <= 1'b0;
      last_d_q    <= 1'b0;
      wen_q       <= 1'b0;
      timed_out_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q     <= grant_d;
            wen_q       <= grant_d & dwen_i;
            addr_q      <= grant_d ?
                           {daddr_i[ADDR_W-1:BYTE_ADDR_BITS], {BYTE_ADDR_BITS{1'b0}}} :
                           {iaddr_i[ADDR_W-1:BYTE_ADDR_BITS], {BYTE_ADDR_BITS{1'b0}}};
            wdata_q     <= grant_d ? dwdata_i : '0;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
          end
        end
        StWait: begin
          if (mem_ready_i) begin
            if (!wen_q) rdata_q <= mem_rdata_i;
          end else if (cnt_expired) begin
            timed_out_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp:  last_d_q <= owner_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_valid_o = 1'b0;
    mem_wen_o   = 1'b0;
    mem_raddr_o = '0;
    mem_waddr_o = '0;
    mem_wdata_o = '0;
    iack_o      = 1'b0;
    dack_o      = 1'b0;
    err_o       = 1'b0;
    unique case (state_q)
      StIssue: begin
        mem_valid_o = 1'b1;
        mem_wen_o   = wen_q;
        mem_raddr_o = addr_q;
        mem_waddr_o = addr_q;
        mem_wdata_o = wdata_q;
      end
      StResp: begin
        iack_o = ~owner_q;
        dack_o = owner_q;
        err_o  = timed_out_q;
      end
      default: ;
    endcase
  end

  assign rdata_o = rdata_q;

endmodule
